// File: rtl/expr_stream_checker_if.sv
// Character-stream bus between a char source and expr_stream_checker.
//   master : drives in/in_valid, observes out/err/depth/len
//   slave  : the checker; consumes in/in_valid, drives the status outputs
// DEPTH_W must equal $clog2(MAX_DEPTH+1) of the attached checker; CNT_W its CNT_W.
interface expr_stream_checker_if #(
    parameter int unsigned DEPTH_W = 3,
    parameter int unsigned CNT_W   = 8
);
    logic [7:0]         in;
    logic               in_valid;
    logic               out;
    logic               err;
    logic [DEPTH_W-1:0] depth;
    logic [CNT_W-1:0]   len;

    modport master (output in, in_valid, input out, err, depth, len);
    modport slave  (input in, in_valid, output out, err, depth, len);
endinterface

// File: rtl/expr_stream_checker.sv
// Streaming validator for infix arithmetic expressions, one ASCII char per
// consumed cycle. Operands are up to MAX_DIGITS decimal digits, operators are
// + - * /. Optional nested parentheses are enabled by defining EXPR_PAREN_EN;
// without it '(' and ')' are illegal and depth reads 0.
// Ports:
//   clk         rising-edge clock
//   clr         asynchronous, active-high reset
//   bus.in      ASCII char, consumed on an edge where bus.in_valid=1
//   bus.out     1 = chars consumed since clr form a complete valid expression
//   bus.err     sticky error flag (illegal char or limit violation)
//   bus.depth   current open-paren count
//   bus.len     chars consumed since clr, saturating
module expr_stream_checker #(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned MAX_DEPTH  = 7,
    parameter int unsigned CNT_W      = 8
) (
    input logic                  clk,
    input logic                  clr,
    expr_stream_checker_if.slave bus
);
    localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int unsigned DIG_W   = $clog2(MAX_DIGITS + 1);

    localparam logic [2:0] S_START = 3'd0;
    localparam logic [2:0] S_NUM   = 3'd1;
    localparam logic [2:0] S_OPND  = 3'd2;
    localparam logic [2:0] S_CLOSE = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [DIG_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             out_q, out_d;
    logic             err_q, err_d;
    logic             is_dig, is_op;
`ifdef EXPR_PAREN_EN
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               is_lp, is_rp;
`endif

    // Character classification
    always_comb begin
        is_dig = (bus.in >= 8'h30) && (bus.in <= 8'h39);
        is_op  = (bus.in == 8'h2B) || (bus.in == 8'h2D) ||
                 (bus.in == 8'h2A) || (bus.in == 8'h2F);
`ifdef EXPR_PAREN_EN
        is_lp  = (bus.in == 8'h28);
        is_rp  = (bus.in == 8'h29);
`endif
    end

    // Next-state and next-output logic; everything holds when no char is consumed
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        len_d   = len_q;
        out_d   = out_q;
        err_d   = err_q;
`ifdef EXPR_PAREN_EN
        depth_d = depth_q;
`endif
        if (bus.in_valid) begin
            case (state_q)
                S_START, S_OPND: begin
                    if (is_dig) begin
                        state_d = S_NUM;
                        dcnt_d  = DIG_W'(1);
                    end
`ifdef EXPR_PAREN_EN
                    else if (is_lp) begin
                        // Overflowing '(' errors out; depth keeps its last value
                        if (depth_q == DEPTH_W'(MAX_DEPTH)) state_d = S_ERR;
                        else depth_d = depth_q + DEPTH_W'(1);
                    end
`endif
                    else state_d = S_ERR;
                end
                S_NUM: begin
                    if (is_dig) begin
                        if (dcnt_q == DIG_W'(MAX_DIGITS)) state_d = S_ERR;
                        else dcnt_d = dcnt_q + DIG_W'(1);
                    end
                    else if (is_op) state_d = S_OPND;
`ifdef EXPR_PAREN_EN
                    else if (is_rp && (depth_q != '0)) begin
                        state_d = S_CLOSE;
                        depth_d = depth_q - DEPTH_W'(1);
                    end
`endif
                    else state_d = S_ERR;
                end
                S_CLOSE: begin
                    if (is_op) state_d = S_OPND;
`ifdef EXPR_PAREN_EN
                    else if (is_rp && (depth_q != '0)) begin
                        depth_d = depth_q - DEPTH_W'(1);
                    end
`endif
                    else state_d = S_ERR;
                end
                default: state_d = S_ERR;
            endcase

            if (len_q != '1) len_d = len_q + CNT_W'(1);

`ifdef EXPR_PAREN_EN
            out_d = ((state_d == S_NUM) || (state_d == S_CLOSE)) && (depth_d == '0);
`else
            out_d = (state_d == S_NUM);
`endif
            err_d = err_q | (state_d == S_ERR);
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_START;
            dcnt_q  <= '0;
            len_q   <= '0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef EXPR_PAREN_EN
            depth_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            len_q   <= len_d;
            out_q   <= out_d;
            err_q   <= err_d;
`ifdef EXPR_PAREN_EN
            depth_q <= depth_d;
`endif
        end
    end

    assign bus.out = out_q;
    assign bus.err = err_q;
    assign bus.len = len_q;
`ifdef EXPR_PAREN_EN
    assign bus.depth = depth_q;
`else
    assign bus.depth = DEPTH_W'(0);
`endif
endmodule
